// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and constants for the multiply/divide sequencer.
`default_nettype none

package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned ITER_W     = $clog2(DEF_WIDTH);
    localparam logic [31:0] INT_MIN_32 = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: start/operand/result bundle between the DX/PW latches and the unit.
`default_nettype none

interface multdiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

`default_nettype wire

// File: rtl/multdiv_iter_counter.sv
// multdiv_iter_counter: iteration counter, cleared on an accepted start, flags the last step.
`default_nettype none

module multdiv_iter_counter
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = ITER_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign tc_o = (count_q == CNT_W'(WIDTH - 1));
endmodule

`default_nettype wire

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle signed Booth multiply / restoring divide for the execute stage.
// Optional macro MULTDIV_EXCEPTION_EN builds the overflow / divide-by-zero exception flag.
`default_nettype none

module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    multdiv_sequencer_if.slave md_if
);
    state_e             state_q, state_d;
    logic [2*WIDTH:0]   prod_q;
    logic [WIDTH-1:0]   mcand_q, rem_q, quo_q, dvsr_q, result_q;
    logic               is_div_q, dz_q, neg_q, busy_q, rdy_q;
    logic               w_accept, w_iterating, w_tc;
    logic [WIDTH:0]     w_hi, w_mc_ext, w_booth_hi, w_div_shift, w_div_diff;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_result;

    assign w_accept    = (md_if.ctrl_MULT | md_if.ctrl_DIV) && (state_q == IDLE || state_q == DONE);
    assign w_iterating = (state_q == MUL) || (state_q == DIV);
    assign w_abs_a     = md_if.data_operandA[WIDTH-1] ? -md_if.data_operandA : md_if.data_operandA;
    assign w_abs_b     = md_if.data_operandB[WIDTH-1] ? -md_if.data_operandB : md_if.data_operandB;

    multdiv_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W ($clog2(WIDTH))
    ) u_iter_cnt (
        .clk     (clock),
        .rst     (reset),
        .clear_i (w_accept),
        .inc_i   (w_iterating),
        .tc_o    (w_tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (md_if.ctrl_MULT)     state_d = MUL;
                else if (md_if.ctrl_DIV) state_d = (md_if.data_operandB == '0) ? DONE : DIV;
                else                     state_d = IDLE;
            end
            MUL, DIV: if (w_tc) state_d = DONE;
            default:  state_d = IDLE;
        endcase
    end

    // Upper half carries one guard bit so the add/subtract can never wrap before the shift.
    assign w_hi     = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    assign w_mc_ext = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        w_booth_hi = w_hi;
        case (prod_q[1:0])
            2'b01:   w_booth_hi = w_hi + w_mc_ext;
            2'b10:   w_booth_hi = w_hi - w_mc_ext;
            default: w_booth_hi = w_hi;
        endcase
    end

    assign w_div_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, dvsr_q};
    assign w_result    = dz_q     ? '0 :
                         is_div_q ? (neg_q ? -quo_q : quo_q) :
                                    prod_q[WIDTH:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prod_q   <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == MUL) || (state_d == DIV);
            rdy_q   <= (state_q == DONE);
            if (state_q == DONE) result_q <= w_result;
            if (w_accept) begin
                is_div_q <= ~md_if.ctrl_MULT;
                dz_q     <= ~md_if.ctrl_MULT & ~(|md_if.data_operandB);
                neg_q    <= md_if.data_operandA[WIDTH-1] ^ md_if.data_operandB[WIDTH-1];
                prod_q   <= {{WIDTH{1'b0}}, md_if.data_operandB, 1'b0};
                mcand_q  <= md_if.data_operandA;
                rem_q    <= '0;
                quo_q    <= w_abs_a;
                dvsr_q   <= w_abs_b;
            end else if (state_q == MUL) begin
                prod_q <= {w_booth_hi, prod_q[WIDTH:1]};
            end else if (state_q == DIV) begin
                rem_q <= w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
            end
        end
    end

`ifdef MULTDIV_EXCEPTION_EN
    localparam logic [WIDTH-1:0] C_INT_MIN =
        (WIDTH == 32) ? WIDTH'(INT_MIN_32) : {1'b1, {(WIDTH-1){1'b0}}};

    logic exc_q, divovf_q, w_exc;

    // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension.
    assign w_exc = is_div_q ? (dz_q | divovf_q)
                            : !((&prod_q[2*WIDTH:WIDTH]) || !(|prod_q[2*WIDTH:WIDTH]));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exc_q    <= 1'b0;
            divovf_q <= 1'b0;
        end else begin
            if (w_accept) begin
                divovf_q <= ~md_if.ctrl_MULT & (md_if.data_operandA == C_INT_MIN)
                            & (&md_if.data_operandB);
            end
            if (state_q == DONE) exc_q <= w_exc;
        end
    end

    assign md_if.data_exception = exc_q;
`else
    assign md_if.data_exception = 1'b0;
`endif

    assign md_if.data_result    = result_q;
    assign md_if.data_resultRDY = rdy_q;
    assign md_if.busy           = busy_q;
endmodule

`default_nettype wire
